uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

- Transmit half of the UART link.
- Accepts parallel words through a valid/ready handshake into a small FIFO, and serialises each word as one frame: start bit, data bits, stop bit.
- Data bits are sent MSB first, matching the receive block's MSB-first storage order.
- Its output drives the serial line consumed by the UART receiver.

## Interface
- `CLK_CYCLES`, default 868: clock cycles per bit (clk_freq / baud). Legal range 2..65535.
- `BIT_NUM`, default 8: data bits per frame. Legal range 1..15.
- `FIFO_DEPTH`, default 4: word buffer depth. Power of two, ≥ 2.
- One clock; reset is synchronous and active-high. The ports are:
- `i_clk` input 1: clock. All state changes on the rising edge.
- `i_rst` input 1: synchronous reset, active-high.
- `i_tx_data` input `BIT_NUM`: word to transmit.
- `i_tx_valid` input 1: `i_tx_data` is valid.
- `o_tx_ready` output 1: FIFO can accept a word. Equals `!full && !i_rst`.
- `o_tx_serial` output 1: serial line, registered. Idles high.
- `o_tx_busy` output 1: high while the FSM is outside IDLE.
- `o_tx_done` output 1: one-cycle pulse at the end of each stop bit.
- `o_fifo_count` output `$clog2(FIFO_DEPTH)+1`: number of words currently buffered.

## Operation
- **Push:** occurs on any edge where `i_tx_valid && o_tx_ready`. The word is written at the write pointer; pointers wrap modulo `FIFO_DEPTH`.
  - While `o_tx_ready` is low, `i_tx_valid` is ignored: no write and no overwrite.
- **Pop:** the FSM removes the head word into a `BIT_NUM`-bit shift register.
  - Push and pop on the same edge leave the count unchanged.
  - A push to a full FIFO is impossible, because ready is low.
  - No bypass: a word pushed into an empty FIFO is popped at the following edge, at the earliest.
- **Counters:** the bit timer is 16 bits wide and counts 0..`CLK_CYCLES`-1. The bit index counts 0..`BIT_NUM`-1.
- FSM states:
  - **IDLE:** serial line = 1. If the FIFO is non-empty: pop, clear the timer, go to START.
  - **START:** serial line = 0 for `CLK_CYCLES` cycles. When timer = `CLK_CYCLES`-1: clear the timer, go to DATA.
  - **DATA:** serial line = shift register MSB. When timer = `CLK_CYCLES`-1:
    - Shift left by one and increment the bit index.
    - After bit index `BIT_NUM`-1, go to STOP.
  - **STOP:** serial line = 1 for `CLK_CYCLES` cycles. When timer = `CLK_CYCLES`-1:
    - Pulse `o_tx_done`.
    - If the FIFO is non-empty: pop and go directly to START, so there is no idle gap between frames.
    - Otherwise go to IDLE.
  - Any unreachable state encoding: go to IDLE, serial line = 1.
- **Reset** (including mid-frame):
  - Frame aborted, FIFO flushed, state IDLE.
  - Outputs: `o_tx_serial`=1, `o_tx_busy`=0, `o_tx_done`=0, `o_fifo_count`=0, `o_tx_ready`=0 while `i_rst` is high, 1 after release.
  - No done pulse is emitted for an aborted frame.

## Timing
- Frame length: exactly (`BIT_NUM`+2)·`CLK_CYCLES` cycles, from the first low cycle to the end of the stop bit.
- Latency, from a push at edge E into an empty FIFO with the FSM in IDLE:
  - Pop at edge E+1.
  - `o_tx_serial` is low starting at edge E+1.
  - `o_tx_busy` is high from edge E+1.
- `o_tx_done` is high for the single cycle after the edge that ends the stop bit. In the back-to-back case, that edge also starts the next START.
- `o_fifo_count` updates at the push/pop edge. `o_tx_ready` follows it combinationally.
- Back-to-back frames: successive start bits are exactly (`BIT_NUM`+2)·`CLK_CYCLES` cycles apart.

## Test plan
All scenarios use `CLK_CYCLES`=4, `BIT_NUM`=8, `FIFO_DEPTH`=4.

1. **Reset:** hold `i_rst` for 3 cycles while `i_tx_valid`=1.
   - During reset: `o_tx_ready`=0, `o_tx_serial`=1, busy=0, done=0, count=0.
   - After release: ready=1.
2. **Single frame:** push 0xA5 into an idle block.
   - Line reads 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles, i.e. 40 cycles total.
   - One done pulse.
   - Looped back into the UART receiver (4, 8), the receiver output = 0xA5.
3. **FIFO full and ordering:** push 0x01..0x06 with valid held high.
   - Ready drops when count = 4; no word is lost or duplicated.
   - Frames go out in order 0x01..0x06, start bits 40 cycles apart.
   - 6 done pulses; count returns to 0.
4. **Simultaneous push and pop:** count = 1 during frame A, push at the edge that ends A's stop bit.
   - Count stays 1; the next frame starts with no gap.
5. **Reset mid-frame:** assert `i_rst` during DATA bit 3 of 0xFF, with 2 words queued.
   - Line = 1 at the next edge, count = 0, no done pulse.
   - After release, push 0x3C: transmitted correctly and received as 0x3C.
6. **Valid while not ready:** FIFO full, drive `i_tx_data`=0x77 with valid high for 10 cycles.
   - 0x77 is never transmitted.
   - The 4 buffered words are unchanged.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small word FIFO feeding a start/data/stop serialiser.
// Data bits leave MSB first; the serial line is registered and idles high.
module uart_tx_buffered #(
   parameter int unsigned CLK_CYCLES = 868,
   parameter int unsigned BIT_NUM    = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [BIT_NUM-1:0]            i_tx_data,
   input  logic                          i_tx_valid,
   output logic                          o_tx_ready,
   output logic                          o_tx_serial,
   output logic                          o_tx_busy,
   output logic                          o_tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [15:0]     TimerMax = 16'(CLK_CYCLES - 1);
   localparam logic [3:0]      BitMax   = 4'(BIT_NUM - 1);
   localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // ---------------------------------------------------------------- FIFO
   logic [BIT_NUM-1:0] mem_q [FIFO_DEPTH];
   logic [BIT_NUM-1:0] mem_d [FIFO_DEPTH];
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               fifo_full, fifo_empty;
   logic               push, pop;
   logic [BIT_NUM-1:0] head;

   assign fifo_full  = (count_q == CntFull);
   assign fifo_empty = (count_q == '0);
   assign o_tx_ready = !fifo_full && !i_rst;
   assign push       = i_tx_valid && o_tx_ready;
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = i_tx_data;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   // ---------------------------------------------------------------- serialiser
   state_e             state_q, state_d;
   logic [15:0]        timer_q, timer_d;
   logic [3:0]         bit_idx_q, bit_idx_d;
   logic [BIT_NUM-1:0] shreg_q, shreg_d;
   logic [BIT_NUM-1:0] shreg_shl;
   logic               serial_q, serial_d;
   logic               done_q, done_d;
   logic               timer_end;

   assign timer_end = (timer_q == TimerMax);

   // serial_d is the line level for the cycle after this edge, so the
   // line changes on the same edge the state does.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 16'd1;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      shreg_shl = shreg_q << 1;
      serial_d  = serial_q;
      done_d    = 1'b0;
      pop       = 1'b0;

      case (state_q)
         StIdle: begin
            timer_d  = '0;
            serial_d = 1'b1;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shreg_d   = head;
               bit_idx_d = '0;
               serial_d  = 1'b0;
               state_d   = StStart;
            end
         end

         StStart: begin
            serial_d = 1'b0;
            if (timer_end) begin
               timer_d  = '0;
               serial_d = shreg_q[BIT_NUM-1];
               state_d  = StData;
            end
         end

         StData: begin
            serial_d = shreg_q[BIT_NUM-1];
            if (timer_end) begin
               timer_d   = '0;
               shreg_d   = shreg_shl;
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q == BitMax) begin
                  serial_d = 1'b1;
                  state_d  = StStop;
               end else begin
                  serial_d = shreg_shl[BIT_NUM-1];
               end
            end
         end

         StStop: begin
            serial_d = 1'b1;
            if (timer_end) begin
               timer_d = '0;
               done_d  = 1'b1;
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shreg_d   = head;
                  bit_idx_d = '0;
                  serial_d  = 1'b0;
                  state_d   = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         default: begin
            timer_d  = '0;
            serial_d = 1'b1;
            state_d  = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         serial_q  <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         serial_q  <= serial_d;
         done_q    <= done_d;
      end
   end

   assign o_tx_serial  = serial_q;
   assign o_tx_busy    = (state_q != StIdle);
   assign o_tx_done    = done_q;
   assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: vector table of single frames plus
// directed sequences for FIFO fill, push/pop collision, mid-frame reset and overflow.
module tb_uart_tx_buffered;

   localparam int CLK_CYCLES = 4;
   localparam int BIT_NUM    = 8;
   localparam int FIFO_DEPTH = 4;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic [7:0] tx_data  = 8'h55;
   logic       tx_valid = 1'b1;
   logic       tx_ready;
   logic       tx_serial;
   logic       tx_busy;
   logic       tx_done;
   logic [2:0] fifo_count;

   always #5 clk = ~clk;

   uart_tx_buffered #(
      .CLK_CYCLES (CLK_CYCLES),
      .BIT_NUM    (BIT_NUM),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_tx_data    (tx_data),
      .i_tx_valid   (tx_valid),
      .o_tx_ready   (tx_ready),
      .o_tx_serial  (tx_serial),
      .o_tx_busy    (tx_busy),
      .o_tx_done    (tx_done),
      .o_fifo_count (fifo_count)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Line receiver model: samples mid-bit (4 cycles/bit), MSB first.
   int         cyc        = 0;
   int         done_cnt   = 0;
   int         stop_err   = 0;
   int         rx_cnt     = 0;
   int         st_cnt     = 0;
   int         mon_cnt    = 0;
   logic       mon_active = 1'b0;
   logic [7:0] mon_sh     = 8'h00;
   logic [7:0] rx_mem [256];
   int         st_mem [256];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
      if (rst) begin
         mon_active <= 1'b0;
      end else if (!mon_active) begin
         if (tx_serial === 1'b0) begin
            mon_active     <= 1'b1;
            mon_cnt        <= 1;
            st_mem[st_cnt] <= cyc;
            st_cnt         <= st_cnt + 1;
         end
      end else begin
         mon_cnt <= mon_cnt + 1;
         if (mon_cnt % 4 == 2) begin
            if (mon_cnt / 4 == 0) begin
               if (tx_serial !== 1'b0) stop_err <= stop_err + 1;
            end else if (mon_cnt / 4 <= 8) begin
               mon_sh <= {mon_sh[6:0], tx_serial};
            end else begin
               if (tx_serial !== 1'b1) stop_err <= stop_err + 1;
               rx_mem[rx_cnt] <= mon_sh;
               rx_cnt         <= rx_cnt + 1;
               mon_active     <= 1'b0;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_rx(input string name, input int target, input int budget);
      int k = 0;
      while (rx_cnt < target && k < budget) begin
         tick(1);
         k++;
      end
      chk(name, 32'(rx_cnt >= target), 32'd1);
   endtask

   logic [7:0] push_q [$];

   // Push everything queued, honouring ready; checks ready against the count.
   task automatic push_all(input string name, input int budget, output bit saw_full);
      int   k = 0;
      logic r;
      saw_full = 1'b0;
      while (push_q.size() > 0 && k < budget) begin
         tx_data  = push_q[0];
         tx_valid = 1'b1;
         #0;
         chk({name, "_ready"}, 32'(tx_ready), 32'(fifo_count != 3'd4));
         if (fifo_count == 3'd4) saw_full = 1'b1;
         r = tx_ready;
         tick(1);
         if (r) void'(push_q.pop_front());
         k++;
      end
      tx_valid = 1'b0;
      chk({name, "_drained"}, 32'(push_q.size()), 32'd0);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] line; // bit 9 goes out first: start, d7..d0, stop
   } vec_t;

   vec_t vecs [6];

   initial begin
      int  r0, d0, s0;
      bit  full_seen;

      vecs[0] = '{data: 8'hA5, line: 10'b0_10100101_1};
      vecs[1] = '{data: 8'h3C, line: 10'b0_00111100_1};
      vecs[2] = '{data: 8'h00, line: 10'b0_00000000_1};
      vecs[3] = '{data: 8'hFF, line: 10'b0_11111111_1};
      vecs[4] = '{data: 8'h80, line: 10'b0_10000000_1};
      vecs[5] = '{data: 8'h01, line: 10'b0_00000001_1};

      // 1. Reset held for 3 cycles with valid high
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("rst_ready", 32'(tx_ready), 32'd0);
         chk("rst_serial", 32'(tx_serial), 32'd1);
         chk("rst_busy", 32'(tx_busy), 32'd0);
         chk("rst_done", 32'(tx_done), 32'd0);
         chk("rst_count", 32'(fifo_count), 32'd0);
      end
      rst      = 1'b0;
      tx_valid = 1'b0;
      #1;
      chk("rel_ready", 32'(tx_ready), 32'd1);
      tick(2);

      // 2. Single frames from the vector table
      for (int i = 0; i < 6; i++) begin
         r0 = rx_cnt;
         d0 = done_cnt;
         chk("vec_idle_busy", 32'(tx_busy), 32'd0);
         tx_data  = vecs[i].data;
         tx_valid = 1'b1;
         tick(1);
         tx_valid = 1'b0;
         chk("vec_push_count", 32'(fifo_count), 32'd1);
         chk("vec_no_bypass", 32'(tx_serial), 32'd1);
         tick(1);
         chk("vec_pop_count", 32'(fifo_count), 32'd0);
         chk("vec_busy", 32'(tx_busy), 32'd1);
         for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CLK_CYCLES; j++) begin
               chk("vec_line", 32'(tx_serial), 32'(vecs[i].line[9-k]));
               tick(1);
            end
         end
         chk("vec_done_hi", 32'(tx_done), 32'd1);
         chk("vec_end_busy", 32'(tx_busy), 32'd0);
         tick(1);
         chk("vec_done_lo", 32'(tx_done), 32'd0);
         chk("vec_done_cnt", 32'(done_cnt - d0), 32'd1);
         chk("vec_rx_cnt", 32'(rx_cnt - r0), 32'd1);
         chk("vec_rx_data", 32'(rx_mem[r0]), 32'(vecs[i].data));
         tick(2);
      end

      // 3. FIFO fill and ordering
      r0 = rx_cnt;
      d0 = done_cnt;
      s0 = st_cnt;
      for (int i = 1; i <= 6; i++) push_q.push_back(8'(i));
      push_all("fill", 200, full_seen);
      chk("fill_saw_full", 32'(full_seen), 32'd1);
      wait_rx("fill_rx_timeout", r0 + 6, 600);
      tick(4);
      for (int i = 0; i < 6; i++) chk("fill_order", 32'(rx_mem[r0+i]), 32'(i + 1));
      for (int i = 1; i < 6; i++) chk("fill_gap", 32'(st_mem[s0+i] - st_mem[s0+i-1]), 32'd40);
      chk("fill_done_cnt", 32'(done_cnt - d0), 32'd6);
      chk("fill_count_end", 32'(fifo_count), 32'd0);
      tick(2);

      // 4. Push on the edge that ends frame A's stop bit
      r0 = rx_cnt;
      s0 = st_cnt;
      tx_data  = 8'hC1;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      tick(4);
      tx_data  = 8'hC2;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      chk("pp_count_a", 32'(fifo_count), 32'd1);
      tick(35);
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      chk("pp_ready", 32'(tx_ready), 32'd1);
      chk("pp_count_pre", 32'(fifo_count), 32'd1);
      tick(1);
      tx_valid = 1'b0;
      chk("pp_count_post", 32'(fifo_count), 32'd1);
      chk("pp_done", 32'(tx_done), 32'd1);
      chk("pp_no_gap", 32'(tx_serial), 32'd0);
      chk("pp_busy", 32'(tx_busy), 32'd1);
      wait_rx("pp_rx_timeout", r0 + 3, 300);
      chk("pp_rx0", 32'(rx_mem[r0]), 32'hC1);
      chk("pp_rx1", 32'(rx_mem[r0+1]), 32'hC2);
      chk("pp_rx2", 32'(rx_mem[r0+2]), 32'hC3);
      chk("pp_gap1", 32'(st_mem[s0+1] - st_mem[s0]), 32'd40);
      chk("pp_gap2", 32'(st_mem[s0+2] - st_mem[s0+1]), 32'd40);
      tick(6);

      // 5. Reset during DATA bit 3 with two words queued
      d0 = done_cnt;
      r0 = rx_cnt;
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      tick(1);
      tx_data  = 8'h11;
      tick(1);
      tx_data  = 8'h22;
      tick(1);
      tx_valid = 1'b0;
      chk("mr_count_q", 32'(fifo_count), 32'd2);
      tick(16);
      rst = 1'b1;
      tick(1);
      chk("mr_serial", 32'(tx_serial), 32'd1);
      chk("mr_count", 32'(fifo_count), 32'd0);
      chk("mr_busy", 32'(tx_busy), 32'd0);
      chk("mr_done", 32'(tx_done), 32'd0);
      chk("mr_ready", 32'(tx_ready), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(60);
      chk("mr_no_done", 32'(done_cnt - d0), 32'd0);
      chk("mr_no_rx", 32'(rx_cnt - r0), 32'd0);
      chk("mr_idle_line", 32'(tx_serial), 32'd1);
      d0 = done_cnt;
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      wait_rx("mr_rx_timeout", r0 + 1, 100);
      tick(4);
      chk("mr_rx_data", 32'(rx_mem[r0]), 32'h3C);
      chk("mr_done_cnt", 32'(done_cnt - d0), 32'd1);
      tick(2);

      // 6. Valid held while full must not overwrite or enqueue
      r0 = rx_cnt;
      for (int i = 0; i < 5; i++) push_q.push_back(8'(8'h41 + i));
      push_all("ovf", 50, full_seen);
      chk("ovf_full", 32'(fifo_count), 32'd4);
      tx_data  = 8'h77;
      tx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("ovf_ready", 32'(tx_ready), 32'd0);
         tick(1);
         chk("ovf_count", 32'(fifo_count), 32'd4);
      end
      tx_valid = 1'b0;
      wait_rx("ovf_rx_timeout", r0 + 5, 600);
      for (int i = 0; i < 5; i++) chk("ovf_order", 32'(rx_mem[r0+i]), 32'(8'h41 + i));
      tick(100);
      chk("ovf_no_extra", 32'(rx_cnt - r0), 32'd5);
      chk("frame_errors", 32'(stop_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

endmodule
